fetch_unit: RTL and testbench

//  Instruction fetch/PC stage directly downstream of the four-phase strobe generator.

---
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch/PC stage driven by four-phase strobes (optional checker: PHASE_CHECK_EN)
// Ports: CLK/RESET (async active-high); PH_FT/PH_DC/PH_EX/PH_WB phase strobes;
//   START/JMP/HLT/JMP_ADDR sampled on PH_WB; ROM_DATA in, ROM_ADDR out (= PC);
//   PC_OUT, IR, IR_VALID, HALTED, PHASE_ERR (sticky, only with PHASE_CHECK_EN).
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int INSN_W = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PH_FT,
  input  logic              PH_DC,
  input  logic              PH_EX,
  input  logic              PH_WB,
  input  logic              START,
  input  logic [INSN_W-1:0] ROM_DATA,
  input  logic              JMP,
  input  logic [ADDR_W-1:0] JMP_ADDR,
  input  logic              HLT,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic [INSN_W-1:0] IR,
  output logic              IR_VALID,
  output logic              HALTED,
  output logic              PHASE_ERR
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc;
  logic hold;
  assign ROM_ADDR = pc;
  assign PC_OUT = pc;
`ifdef PHASE_CHECK_EN
  logic [3:0] strobes;
  logic [1:0] exp_ph;
  logic bad;
  assign strobes = {PH_WB, PH_EX, PH_DC, PH_FT};
  // any active strobe pattern other than exactly the expected one-hot is an error
  assign bad = |strobes && strobes != (4'b0001 << exp_ph);
  assign hold = PHASE_ERR | bad;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      PHASE_ERR <= 1'b0;
      exp_ph <= 2'd0;
    end else if (bad) PHASE_ERR <= 1'b1;
    else if (|strobes) exp_ph <= exp_ph + 2'd1;
`else
  logic unused_ph;
  assign unused_ph = PH_DC ^ PH_EX;
  assign PHASE_ERR = 1'b0;
  assign hold = 1'b0;
`endif
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      pc <= RESET_PC;
      IR <= '0;
      IR_VALID <= 1'b0;
      HALTED <= 1'b0;
    end else if (!hold)
      case (state)
        IDLE: if (PH_WB && START) state <= RUN;
        RUN: begin
          if (PH_FT) begin
            IR <= ROM_DATA;
            IR_VALID <= 1'b1;
          end
          if (PH_WB) begin
            if (HLT) begin
              state <= HALT;
              HALTED <= 1'b1;
            end else pc <= JMP ? JMP_ADDR : pc + 1'b1;
          end
        end
        default: ;
      endcase
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] ph = '0;
  logic start = 1'b0, jmp = 1'b0, hlt = 1'b0;
  logic [7:0] ja = '0;
  logic [14:0] rom_xor = '0;
  logic [7:0] rom_addr, pc_out;
  logic [14:0] rom_data, ir;
  logic ir_valid, halted, phase_err;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign rom_data = ({7'b0, rom_addr} + 15'h100) ^ rom_xor;
  fetch_unit dut (
    .CLK(clk), .RESET(rst), .PH_FT(ph[0]), .PH_DC(ph[1]), .PH_EX(ph[2]), .PH_WB(ph[3]),
    .START(start), .ROM_DATA(rom_data), .JMP(jmp), .JMP_ADDR(ja), .HLT(hlt),
    .ROM_ADDR(rom_addr), .PC_OUT(pc_out), .IR(ir), .IR_VALID(ir_valid),
    .HALTED(halted), .PHASE_ERR(phase_err)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic step(input logic [3:0] p);
    ph = p;
    @(posedge clk);
    #1;
    ph = '0;
  endtask
  task automatic rot();
    step(4'b0001); step(4'b0010); step(4'b0100); step(4'b1000);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    #1;
    check("rst_pc", pc_out, 0);
    check("rst_ir", ir, 0);
    check("rst_valid", ir_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_err", phase_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b1; rot(); start = 1'b0;
    check("t1_start_pc", pc_out, 0);
    check("t1_start_valid", ir_valid, 0);
    step(4'b0001);
    check("t1_ir0", ir, 15'h100);
    check("t1_valid", ir_valid, 1);
    step(4'b0010); step(4'b0100); step(4'b1000);
    check("t1_pc1", pc_out, 1);
    check("t1_romaddr", rom_addr, 1);
    rot();
    check("t1_ir1", ir, 15'h101);
    check("t1_pc2", pc_out, 2);
    rot();
    check("t1_ir2", ir, 15'h102);
    jmp = 1'b1; ja = 8'h05; rot(); jmp = 1'b0;
    check("t2_pc5", pc_out, 8'h05);
    step(4'b0001); step(4'b0010);
    jmp = 1'b1; ja = 8'h40; hlt = 1'b1; step(4'b0100); jmp = 1'b0; hlt = 1'b0;
    step(4'b1000);
    check("t2_jmp_ex_ignored", pc_out, 8'h06);
    check("t2_hlt_ex_ignored", halted, 0);
    jmp = 1'b1; ja = 8'h40; rot(); jmp = 1'b0;
    check("t2_pc40", pc_out, 8'h40);
    step(4'b0001);
    check("t2_ir40", ir, 15'h140);
    step(4'b0010); step(4'b0100);
    jmp = 1'b1; step(4'b1000); jmp = 1'b0;
    check("t2_selfloop", pc_out, 8'h40);
    jmp = 1'b1; ja = 8'hFF; rot(); jmp = 1'b0;
    check("t3_pcff", pc_out, 8'hFF);
    step(4'b0001);
    check("t3_irff", ir, 15'h1FF);
    step(4'b0010); step(4'b0100); step(4'b1000);
    check("t3_wrap", pc_out, 8'h00);
    step(4'b0001);
    check("t3_ir_after_wrap", ir, 15'h100);
    step(4'b0010); step(4'b0100); step(4'b1000);
    check("t3_pc1", pc_out, 8'h01);
    jmp = 1'b1; ja = 8'h10; rot();
    hlt = 1'b1; ja = 8'h20; rot(); hlt = 1'b0; jmp = 1'b0;
    check("t4_halted", halted, 1);
    check("t4_pc_hold", pc_out, 8'h10);
    check("t4_ir", ir, 15'h110);
    rom_xor = 15'h7000; start = 1'b1; jmp = 1'b1; rot(); rot();
    rom_xor = '0; start = 1'b0; jmp = 1'b0;
    check("t4_frozen_pc", pc_out, 8'h10);
    check("t4_frozen_ir", ir, 15'h110);
    check("t4_frozen_valid", ir_valid, 1);
    check("t4_still_halted", halted, 1);
    rst = 1'b1;
    #1;
    check("t4_rst_pc", pc_out, 0);
    check("t4_rst_halted", halted, 0);
    check("t4_rst_ir", ir, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rot();
    check("t4_idle_pc", pc_out, 0);
    check("t4_idle_valid", ir_valid, 0);
    start = 1'b1; rot(); start = 1'b0;
    rot();
    step(4'b0001); step(4'b0010);
    check("t5_pre_pc", pc_out, 1);
    check("t5_pre_ir", ir, 15'h101);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_pc", pc_out, 0);
    check("t5_async_ir", ir, 0);
    check("t5_async_valid", ir_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b1; rot(); start = 1'b0;
    step(4'b0101);
`ifdef PHASE_CHECK_EN
    check("t6_multi_err", phase_err, 1);
    check("t6_multi_ir", ir, 0);
    check("t6_multi_valid", ir_valid, 0);
`else
    check("t6_multi_err", phase_err, 0);
    check("t6_multi_ir", ir, 15'h100);
    check("t6_multi_valid", ir_valid, 1);
`endif
    step(4'b0010); step(4'b0100); step(4'b1000);
`ifdef PHASE_CHECK_EN
    check("t6_multi_pc", pc_out, 0);
`else
    check("t6_multi_pc", pc_out, 1);
`endif
    do_reset();
    check("t6_err_cleared", phase_err, 0);
    start = 1'b1; rot(); start = 1'b0;
    step(4'b0001);
    check("t6_ir", ir, 15'h100);
    step(4'b0100);
`ifdef PHASE_CHECK_EN
    check("t6_order_err", phase_err, 1);
`else
    check("t6_order_err", phase_err, 0);
`endif
    step(4'b1000);
`ifdef PHASE_CHECK_EN
    check("t6_order_pc", pc_out, 0);
`else
    check("t6_order_pc", pc_out, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
